grant_decoder_fsm: RTL

- Receiving end of the arbiter/83-encoder path: takes a binary grant index plus valid.
- Decodes it into a registered one-hot grant vector and holds that grant until the owning requester signals done, or until a hold timeout expires.
- Sits between the central arbiter/encoder and the N requester clients; guarantees at most one grant bit is high in any cycle.

---
 rtl/grant_decoder_fsm_pkg.sv | 25 ++
 rtl/grant_decoder_fsm_if.sv | 30 +++
 rtl/grant_decoder_fsm_hold_timer.sv | 33 +++
 rtl/grant_decoder_fsm.sv | 134 +++++++++++++
 4 files changed

// File: rtl/grant_decoder_fsm_pkg.sv
// Shared types and helpers for the grant decoder: state encoding, default sizing
// and the binary-index to one-hot decode used by the top.
package grant_decoder_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_W        = 3;
  localparam int DEF_HOLD_MAX = 255;
  localparam int DEF_CW       = 8;

  // Widest grant vector the decode helper can produce; callers truncate to N.
  localparam int MAX_N = 32;

  function automatic logic [MAX_N-1:0] onehot_decode(input logic [31:0] idx);
    logic [MAX_N-1:0] one;
    one = 1;
    onehot_decode = one << idx;
  endfunction

endpackage

// File: rtl/grant_decoder_fsm_if.sv
// Index handshake, per-requester done and grant/status bundle between the
// arbiter/encoder side (master) and the grant decoder (slave).
interface grant_decoder_fsm_if
  import grant_decoder_fsm_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) ();

  logic [W-1:0] bin;
  logic         bin_valid;
  logic         bin_ready;
  logic [N-1:0] done;
  logic [N-1:0] g;
  logic [W-1:0] owner;
  logic         busy;
  logic         timeout_err;
  logic         bad_idx;

  modport master (
    output bin, bin_valid, done,
    input  bin_ready, g, owner, busy, timeout_err, bad_idx
  );

  modport slave (
    input  bin, bin_valid, done,
    output bin_ready, g, owner, busy, timeout_err, bad_idx
  );

endinterface

// File: rtl/grant_decoder_fsm_hold_timer.sv
// Grant hold counter: counts cycles while enabled, saturates at HOLD_MAX and
// flags the last permitted cycle (count == HOLD_MAX-1) while enabled.
module hold_timer
  import grant_decoder_fsm_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CW       = DEF_CW
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] SAT  = CW'(HOLD_MAX);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = en && (count == LAST);

endmodule

// File: rtl/grant_decoder_fsm.sv
// Grant decoder: accepts a binary index, holds a registered one-hot grant until
// done[owner] or hold timeout. GRANT_BACK2BACK_EN allows re-grant on done.
module grant_decoder_fsm
  import grant_decoder_fsm_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CW       = DEF_CW
) (
  input logic                clk,
  input logic                rst,
  grant_decoder_fsm_if.slave bus
);

  // N always fits in W+1 bits because 2**W >= N.
  localparam logic [W:0] N_EXT = (W+1)'(N);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] g_q;
  logic [N-1:0] g_next;
  logic [W-1:0] owner_q;
  logic [W-1:0] owner_next;
  logic         bad_q;
  logic         bad_next;
  logic         timeout;
  logic         timer_clear;
  logic         expire;
  logic         idx_ok;
  logic         done_own;
  logic         transfer;
  logic [N-1:0] g_dec;

  assign idx_ok   = ({1'b0, bus.bin} < N_EXT);
  assign done_own = (state == ST_GRANT) && bus.done[owner_q];
  assign g_dec    = N'(onehot_decode(32'(bus.bin)));

`ifdef GRANT_BACK2BACK_EN
  assign bus.bin_ready = (state == ST_IDLE) || done_own;
`else
  assign bus.bin_ready = (state == ST_IDLE);
`endif

  assign transfer = bus.bin_valid && bus.bin_ready;

  hold_timer #(
    .HOLD_MAX (HOLD_MAX),
    .CW       (CW)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .en     (state == ST_GRANT),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      g_q     <= '0;
      owner_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state   <= state_next;
      g_q     <= g_next;
      owner_q <= owner_next;
      bad_q   <= bad_next;
    end
  end

  // The counter is held cleared outside GRANT so every grant starts from zero.
  always_comb begin
    state_next  = state;
    g_next      = g_q;
    owner_next  = owner_q;
    bad_next    = 1'b0;
    timeout     = 1'b0;
    timer_clear = (state != ST_GRANT);
    case (state)
      ST_IDLE: begin
        if (transfer) begin
          if (idx_ok) begin
            state_next = ST_GRANT;
            g_next     = g_dec;
            owner_next = bus.bin;
          end else begin
            bad_next = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (done_own) begin
          state_next = ST_RELEASE;
          g_next     = '0;
          owner_next = '0;
`ifdef GRANT_BACK2BACK_EN
          if (transfer) begin
            if (idx_ok) begin
              state_next  = ST_GRANT;
              g_next      = g_dec;
              owner_next  = bus.bin;
              timer_clear = 1'b1;
            end else begin
              bad_next = 1'b1;
            end
          end
`endif
        end else if (expire) begin
          state_next = ST_RELEASE;
          g_next     = '0;
          owner_next = '0;
          timeout    = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        g_next     = '0;
        owner_next = '0;
      end
    endcase
  end

  // timeout_err marks the final held cycle; bad_idx follows the rejecting edge.
  assign bus.g           = g_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state == ST_GRANT);
  assign bus.timeout_err = timeout;
  assign bus.bad_idx     = bad_q;

endmodule
